dawg_req_driver: RTL

- Initiator for the DAWG partitioned cache set: queues user accesses tagged with a security domain and converts each into the os_req/hitmap then user_req sequence the cache set consumes.
- Holds a per-domain way-allocation table and issues a domain switch only when the domain changes or its table entry was rewritten.
- Samples the cache's hit flag, returns one response per request and keeps per-domain hit/miss statistics.

---
 rtl/dawg_req_driver.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dawg_req_driver.sv
// Request initiator for a DAWG way-partitioned cache set: queues domain-tagged
// accesses, issues a domain switch (os_req + hitmap) when needed, then the
// user access, and returns one response per request with per-domain stats.
module dawg_req_driver #(
    parameter int unsigned NUM_WAYS    = 8,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned REQ_DEPTH   = 4,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned DOM_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // request side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DOM_W-1:0]      req_dom,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    // response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic                  rsp_err,
    output logic [DOM_W-1:0]      rsp_dom,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    // way-allocation table write
    input  logic                  cfg_we,
    input  logic [DOM_W-1:0]      cfg_dom,
    input  logic [NUM_WAYS-1:0]   cfg_hitmap,
    // statistics
    input  logic [DOM_W-1:0]      stat_dom,
    input  logic                  stat_clr,
    output logic [CNT_W-1:0]      stat_hits,
    output logic [CNT_W-1:0]      stat_misses,
    // cache set interface
    output logic                  cl_os_req,
    output logic [NUM_WAYS-1:0]   cl_hitmap,
    output logic                  cl_user_req,
    output logic [ADDR_WIDTH-1:0] cl_addr,
    input  logic                  cl_hit
);

    localparam int unsigned PTR_W  = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int unsigned CNTQ_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SWITCH = 3'd1,
        ACCESS = 3'd2,
        SAMPLE = 3'd3,
        ERR    = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [REQ_DEPTH-1:0][DOM_W-1:0]      fifo_dom;
    logic [REQ_DEPTH-1:0][ADDR_WIDTH-1:0] fifo_addr;
    logic [PTR_W-1:0]                     wr_ptr, rd_ptr;
    logic [CNTQ_W-1:0]                    fifo_cnt;
    logic                                 fifo_full, fifo_empty;
    logic                                 push, pop;
    logic [DOM_W-1:0]                     head_dom;
    logic [ADDR_WIDTH-1:0]                head_addr;

    logic [NUM_DOMAINS-1:0][NUM_WAYS-1:0] dom_tbl;
    logic [DOM_W-1:0]                     cur_dom;
    logic                                 dom_valid;

    logic [NUM_DOMAINS-1:0][CNT_W-1:0]    hit_cnt;
    logic [NUM_DOMAINS-1:0][CNT_W-1:0]    miss_cnt;

    logic                                 os_req_nxt, user_req_nxt;
    logic [NUM_WAYS-1:0]                  hitmap_nxt;
    logic [ADDR_WIDTH-1:0]                addr_nxt;

    assign fifo_full  = (fifo_cnt == CNTQ_W'(REQ_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    assign head_dom   = fifo_dom[rd_ptr];
    assign head_addr  = fifo_addr[rd_ptr];

    assign stat_hits   = hit_cnt[stat_dom];
    assign stat_misses = miss_cnt[stat_dom];

    // Request FIFO; the head stays in place until the access is sampled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fifo_dom  <= '0;
            fifo_addr <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            if (push) begin
                fifo_dom[wr_ptr]  <= req_dom;
                fifo_addr[wr_ptr] <= req_addr;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNTQ_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNTQ_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Way-allocation table; a rewrite of the active domain forces a re-switch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dom_tbl   <= '0;
            cur_dom   <= '0;
            dom_valid <= 1'b0;
        end else begin
            if (cfg_we) begin
                dom_tbl[cfg_dom] <= cfg_hitmap;
            end
            if (state == SWITCH) begin
                cur_dom   <= head_dom;
                dom_valid <= !(cfg_we && (cfg_dom == head_dom));
            end else if (cfg_we && (cfg_dom == cur_dom)) begin
                dom_valid <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, FIFO pop and next values of the registered cache strobes.
    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        os_req_nxt   = 1'b0;
        hitmap_nxt   = '0;
        user_req_nxt = 1'b0;
        addr_nxt     = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (dom_tbl[head_dom] == '0) begin
                        state_nxt = ERR;
                    end else if (!dom_valid || (cur_dom != head_dom)) begin
                        state_nxt = SWITCH;
                    end else begin
                        state_nxt = ACCESS;
                    end
                end
            end
            SWITCH: state_nxt = ACCESS;
            ACCESS: state_nxt = SAMPLE;
            SAMPLE: begin
                pop       = 1'b1;
                state_nxt = RESP;
            end
            ERR: begin
                pop       = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Strobes are registered, so decode them from the state being entered.
        if (state_nxt == SWITCH) begin
            os_req_nxt = 1'b1;
            hitmap_nxt = dom_tbl[head_dom];
        end
        if (state_nxt == ACCESS) begin
            user_req_nxt = 1'b1;
            addr_nxt     = head_addr;
        end
    end

    // Registered cache-side strobes; payloads are zero whenever the strobe is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cl_os_req   <= 1'b0;
            cl_hitmap   <= '0;
            cl_user_req <= 1'b0;
            cl_addr     <= '0;
        end else begin
            cl_os_req   <= os_req_nxt;
            cl_hitmap   <= hitmap_nxt;
            cl_user_req <= user_req_nxt;
            cl_addr     <= addr_nxt;
        end
    end

    // Response register; payload holds until the consumer accepts it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dom   <= '0;
            rsp_addr  <= '0;
        end else begin
            rsp_valid <= (state_nxt == RESP);
            if (state == SAMPLE) begin
                rsp_hit  <= cl_hit;
                rsp_err  <= 1'b0;
                rsp_dom  <= head_dom;
                rsp_addr <= head_addr;
            end else if (state == ERR) begin
                rsp_hit  <= 1'b0;
                rsp_err  <= 1'b1;
                rsp_dom  <= head_dom;
                rsp_addr <= head_addr;
            end
        end
    end

    // Saturating per-domain hit/miss counters; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (stat_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == SAMPLE) begin
            if (cl_hit) begin
                if (hit_cnt[head_dom] != {CNT_W{1'b1}}) begin
                    hit_cnt[head_dom] <= hit_cnt[head_dom] + CNT_W'(1);
                end
            end else begin
                if (miss_cnt[head_dom] != {CNT_W{1'b1}}) begin
                    miss_cnt[head_dom] <= miss_cnt[head_dom] + CNT_W'(1);
                end
            end
        end
    end

endmodule
